// File: rtl/sdfa_inf_serializer.sv
// sdfa_inf_serializer
//
// Holds one {master, block} information word pair per layer and, on a rising
// edge of set_up_req, streams the selected layer's pair MSB-first on two
// serial lines with their own valid strobes. The block stream is shorter
// and finishes first; the master stream sets the transfer length.
//
// Build option: define SDFA_SER_PARITY_EN to append one even-parity bit
// (XOR of the word) after the LSB of each stream.
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous active-high reset (clears table too)
//   cfg_we           table write strobe
//   cfg_addr         table entry written (ignored when >= NUM_LAYERS)
//   cfg_master       master word to write
//   cfg_block        block word to write
//   set_up_req       transfer request level; rising edge triggers in IDLE
//   layer_sel        entry to send (>= NUM_LAYERS sends all-zero words)
//   master_out       serial master bit, 0 outside its valid window
//   master_inf_valid qualifies master_out
//   block_out        serial block bit, 0 outside its valid window
//   block_inf_valid  qualifies block_out
//   busy             high from the first bit through the done cycle
//   send_done        one-cycle pulse after the master stream completes
module sdfa_inf_serializer #(
  parameter int NUM_LAYERS = 8,
  parameter int MASTER_W   = 29,
  parameter int BLOCK_W    = 23
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_addr,
  input  logic [MASTER_W-1:0] cfg_master,
  input  logic [BLOCK_W-1:0]  cfg_block,
  input  logic                set_up_req,
  input  logic [2:0]          layer_sel,
  output logic                master_out,
  output logic                master_inf_valid,
  output logic                block_out,
  output logic                block_inf_valid,
  output logic                busy,
  output logic                send_done
);

`ifdef SDFA_SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // Stream lengths in cycles, including the optional parity bit.
  localparam int LEN_M = MASTER_W + (PAR_EN ? 1 : 0);
  localparam int LEN_B = BLOCK_W + (PAR_EN ? 1 : 0);
  localparam int CNT_W = $clog2(LEN_M + 1);

  localparam logic [CNT_W-1:0] LAST_M = CNT_W'(LEN_M - 1);
  localparam logic [CNT_W-1:0] LEN_B_C = CNT_W'(LEN_B);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t              state;
  logic [MASTER_W-1:0] mst_tbl [NUM_LAYERS];
  logic [BLOCK_W-1:0]  blk_tbl [NUM_LAYERS];
  // One spare LSB per shift register carries the parity bit when enabled.
  logic [MASTER_W:0]   mst_sr;
  logic [BLOCK_W:0]    blk_sr;
  logic [CNT_W-1:0]    cnt;
  logic                req_d;
  logic [MASTER_W-1:0] sel_mst;
  logic [BLOCK_W-1:0]  sel_blk;

  function automatic logic par_bit_m(input logic [MASTER_W-1:0] w);
    return PAR_EN & (^w);
  endfunction

  function automatic logic par_bit_b(input logic [BLOCK_W-1:0] w);
    return PAR_EN & (^w);
  endfunction

  // Table read; an out-of-range layer_sel matches no entry and yields zeros.
  always_comb begin
    sel_mst = '0;
    sel_blk = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (layer_sel == 3'(i)) begin
        sel_mst = mst_tbl[i];
        sel_blk = blk_tbl[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      req_d            <= 1'b0;
      mst_sr           <= '0;
      blk_sr           <= '0;
      master_out       <= 1'b0;
      master_inf_valid <= 1'b0;
      block_out        <= 1'b0;
      block_inf_valid  <= 1'b0;
      busy             <= 1'b0;
      send_done        <= 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        mst_tbl[i] <= '0;
        blk_tbl[i] <= '0;
      end
    end else begin
      req_d <= set_up_req;

      // Writes land at the edge, so a same-cycle launch reads the old entry.
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (cfg_we && (cfg_addr == 3'(i))) begin
          mst_tbl[i] <= cfg_master;
          blk_tbl[i] <= cfg_block;
        end
      end

      // Outputs lag the state by one edge: busy covers SEND and DONE.
      busy             <= (state != IDLE);
      send_done        <= 1'b0;
      master_out       <= 1'b0;
      master_inf_valid <= 1'b0;
      block_out        <= 1'b0;
      block_inf_valid  <= 1'b0;

      case (state)
        IDLE: begin
          if (set_up_req && !req_d) begin
            mst_sr <= {sel_mst, par_bit_m(sel_mst)};
            blk_sr <= {sel_blk, par_bit_b(sel_blk)};
            cnt    <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          master_out       <= mst_sr[MASTER_W];
          master_inf_valid <= 1'b1;
          block_out        <= blk_sr[BLOCK_W] & (cnt < LEN_B_C);
          block_inf_valid  <= (cnt < LEN_B_C);
          mst_sr           <= mst_sr << 1;
          blk_sr           <= blk_sr << 1;
          cnt              <= cnt + 1'b1;
          if (cnt == LAST_M) begin
            state <= DONE;
          end
        end
        DONE: begin
          send_done <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
